// File: rtl/reg_file_pkg.sv
// Shared defaults and operation decode for the register file.
package reg_file_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_ADDR  = 3;
  localparam int unsigned DEF_DEPTH = 2 ** DEF_ADDR;

  // Per-edge operation selected by the enables.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // A write wins when both enables are high; the read is dropped.
  function automatic op_e decode_op(input logic wr_en, input logic rd_en);
    op_e op;
    op = OP_IDLE;
    if (wr_en) begin
      op = OP_WRITE;
    end else if (rd_en) begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Single-port register file: shared address, one-cycle registered read,
// write-over-read priority, synchronous reset clearing all state.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ADDR  = DEF_ADDR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ADDR-1:0]  Address,
  input  logic             WrEn,
  input  logic             RdEn,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] RdData
);

  localparam int unsigned DEPTH = 2 ** ADDR;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;
  op_e              op;

  // Decode the enables and compute next storage and read-data values.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    op        = decode_op(WrEn, RdEn);
    unique case (op)
      OP_WRITE: mem_d[Address] = WrData;
      OP_READ:  rd_data_d      = mem_q[Address];
      default:  ;
    endcase
  end

  // Storage and read-data flops; reset overrides any access on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign RdData = rd_data_q;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ADDR  = 3;

  logic             clk;
  logic             rst;
  logic [ADDR-1:0]  address;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;

  int unsigned n_checks;
  int unsigned n_errors;

  reg_file #(
    .WIDTH(WIDTH),
    .ADDR (ADDR)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .Address(address),
    .WrEn   (wr_en),
    .RdEn   (rd_en),
    .WrData (wr_data),
    .RdData (rd_data)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, return #1 after the rising edge.
  task automatic cycle(input logic r, input logic w, input logic rd,
                       input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    address = a;
    wr_data = d;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
    cycle(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input string tag, input logic [ADDR-1:0] a,
                    input logic [WIDTH-1:0] exp);
    cycle(1'b0, 1'b0, 1'b1, a, 16'h0000);
    check(tag, rd_data, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    address  = '0;
    wr_data  = '0;

    // Reset with a write and read presented on the same edge: reset wins.
    cycle(1'b1, 1'b1, 1'b1, 3'd3, 16'h5555);
    check("reset_rddata", rd_data, 16'h0000);
    rd("reset_read3", 3'd3, 16'h0000);

    // Writes leave RdData untouched.
    wr(3'd7, 16'h0001);
    check("write_holds_rd", rd_data, 16'h0000);
    wr(3'd1, 16'h001C);
    wr(3'd5, 16'h000A);

    rd("read7", 3'd7, 16'h0001);
    rd("read1", 3'd1, 16'h001C);

    // Idle with a moving address holds the last read value.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'(i + 4), 16'h1234);
      check("idle_hold", rd_data, 16'h001C);
    end

    rd("read5", 3'd5, 16'h000A);

    // Simultaneous write+read: write lands, RdData holds.
    cycle(1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF);
    check("wr_rd_hold", rd_data, 16'h000A);
    rd("read2_beef", 3'd2, 16'hBEEF);

    // Write then read on the next cycle returns the new value.
    wr(3'd4, 16'hFFFF);
    rd("read4_new", 3'd4, 16'hFFFF);

    // Reset mid-run discards everything.
    cycle(1'b1, 1'b0, 1'b1, 3'd4, 16'h0000);
    check("midreset_rddata", rd_data, 16'h0000);
    rd("midreset_read4", 3'd4, 16'h0000);
    rd("midreset_read2", 3'd2, 16'h0000);
    rd("midreset_read7", 3'd7, 16'h0000);

    // Full sweep with distinct patterns per entry.
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'(16'h1111 * (i + 1)));
    end
    for (int i = 7; i >= 0; i--) begin
      rd("sweep", 3'(i), 16'(16'h1111 * (i + 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_file
